// File: rtl/apb_master_ctrl_if.sv
// rtl/apb_master_ctrl_if.sv - request, APB and response signal bundle for apb_master_ctrl
// The master modport is the controller's view; slave is the front end / APB fabric view.
interface apb_master_ctrl_if;
  logic        valid;
  logic [31:0] Haddr_temp;
  logic [31:0] Hwdata_temp;
  logic        Hwrite_temp;
  logic        Hreadyout;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Pwrite;
  logic [3:0]  Psel;
  logic        Penable;
  logic        Pready;
  logic [31:0] Prdata;
  logic        Pslverr;
  logic        done;
  logic [31:0] Hrdata;
  logic        Hresp;

  modport master (
    input  valid, Haddr_temp, Hwdata_temp, Hwrite_temp, Pready, Prdata, Pslverr,
    output Hreadyout, Paddr, Pwdata, Pwrite, Psel, Penable, done, Hrdata, Hresp
  );

  modport slave (
    output valid, Haddr_temp, Hwdata_temp, Hwrite_temp, Pready, Prdata, Pslverr,
    input  Hreadyout, Paddr, Pwdata, Pwrite, Psel, Penable, done, Hrdata, Hresp
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - 2-entry request FIFO feeding an APB master FSM with wait-state timeout
// All APB and response outputs are registered; Hreadyout comes straight from the FIFO count.
module apb_master_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic               Hclk,
  input logic               Hreset,
  apb_master_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_addr_mem  [2];
  logic [31:0] r_wdata_mem [2];
  logic        r_write_mem [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_pwrite;
  logic [3:0]  r_psel;
  logic        r_penable;
  logic        r_done;
  logic        r_hresp;
  logic [31:0] r_hrdata;
  logic [7:0]  r_wait;

  logic [31:0] w_paddr_nxt;
  logic [31:0] w_pwdata_nxt;
  logic        w_pwrite_nxt;
  logic [3:0]  w_psel_nxt;
  logic        w_penable_nxt;
  logic        w_done_nxt;
  logic        w_hresp_nxt;
  logic [31:0] w_hrdata_nxt;
  logic [7:0]  w_wait_nxt;

  logic        w_push;
  logic        w_pop;
  logic        w_timeout;
  logic        w_more;
  logic        w_head_idx;
  logic        w_head_bypass;
  logic [31:0] w_head_addr;
  logic [31:0] w_head_wdata;
  logic        w_head_write;

  // Full is judged on the registered count alone, so a pop never frees a slot on the same edge.
  assign w_push    = bus.valid && (r_count < 2'd2);
  assign w_timeout = (r_state == ST_ACCESS) && !bus.Pready && (r_wait == 8'(TIMEOUT - 1));
  assign w_more    = (r_count == 2'd2) || w_push;

  // When leaving ACCESS the next head is the second slot, or the request arriving this edge.
  assign w_head_idx    = (r_state == ST_ACCESS) ? ~r_rd_ptr : r_rd_ptr;
  assign w_head_bypass = (r_state == ST_ACCESS) && (r_count == 2'd1);
  assign w_head_addr   = w_head_bypass ? bus.Haddr_temp  : r_addr_mem[w_head_idx];
  assign w_head_wdata  = w_head_bypass ? bus.Hwdata_temp : r_wdata_mem[w_head_idx];
  assign w_head_write  = w_head_bypass ? bus.Hwrite_temp : r_write_mem[w_head_idx];

  always_ff @(posedge Hclk) begin
    if (w_push) begin
      r_addr_mem[r_wr_ptr]  <= bus.Haddr_temp;
      r_wdata_mem[r_wr_ptr] <= bus.Hwdata_temp;
      r_write_mem[r_wr_ptr] <= bus.Hwrite_temp;
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_pwrite_nxt  = r_pwrite;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_done_nxt    = 1'b0;
    w_hresp_nxt   = 1'b0;
    w_hrdata_nxt  = r_hrdata;
    w_wait_nxt    = r_wait;
    w_pop         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_count != 2'd0) begin
          w_state_nxt   = ST_SETUP;
          w_paddr_nxt   = w_head_addr;
          w_pwdata_nxt  = w_head_wdata;
          w_pwrite_nxt  = w_head_write;
          w_psel_nxt    = 4'b0001 << w_head_addr[13:12];
          w_penable_nxt = 1'b0;
        end
      end

      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_penable_nxt = 1'b1;
        w_wait_nxt    = 8'd0;
      end

      ST_ACCESS: begin
        if (bus.Pready || w_timeout) begin
          w_pop         = 1'b1;
          w_done_nxt    = 1'b1;
          w_hresp_nxt   = bus.Pready ? bus.Pslverr : 1'b1;
          w_penable_nxt = 1'b0;
          if (bus.Pready && !r_pwrite) begin
            w_hrdata_nxt = bus.Prdata;
          end
          if (w_more) begin
            w_state_nxt  = ST_SETUP;
            w_paddr_nxt  = w_head_addr;
            w_pwdata_nxt = w_head_wdata;
            w_pwrite_nxt = w_head_write;
            w_psel_nxt   = 4'b0001 << w_head_addr[13:12];
          end else begin
            w_state_nxt = ST_IDLE;
            w_psel_nxt  = 4'b0000;
          end
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_psel_nxt    = 4'b0000;
        w_penable_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_state   <= ST_IDLE;
      r_paddr   <= 32'd0;
      r_pwdata  <= 32'd0;
      r_pwrite  <= 1'b0;
      r_psel    <= 4'b0000;
      r_penable <= 1'b0;
      r_done    <= 1'b0;
      r_hresp   <= 1'b0;
      r_hrdata  <= 32'd0;
      r_wait    <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_done    <= w_done_nxt;
      r_hresp   <= w_hresp_nxt;
      r_hrdata  <= w_hrdata_nxt;
      r_wait    <= w_wait_nxt;
    end
  end

  assign bus.Hreadyout = (r_count < 2'd2);
  assign bus.Paddr     = r_paddr;
  assign bus.Pwdata    = r_pwdata;
  assign bus.Pwrite    = r_pwrite;
  assign bus.Psel      = r_psel;
  assign bus.Penable   = r_penable;
  assign bus.done      = r_done;
  assign bus.Hresp     = r_hresp;
  assign bus.Hrdata    = r_hrdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - scoreboard bench for apb_master_ctrl built with TIMEOUT = 4
module tb_apb_master_ctrl;

  logic Hclk;
  logic Hreset;

  apb_master_ctrl_if bus ();

  apb_master_ctrl #(.TIMEOUT(4)) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus.master)
  );

  typedef struct packed {
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_hrdata;
  int          n_pass;
  int          n_total;

  int          b_done;
  int          b_gap;
  logic [31:0] b_addrs[$];

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic expect_done(input logic resp, input logic load, input logic [31:0] prdata);
    exp_t e;
    if (load) m_hrdata = prdata;
    e.resp  = resp;
    e.rdata = m_hrdata;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge Hclk);
      if (!Hreset) begin
        if (bus.done) begin
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_done: resp=%0b rdata=%h with empty scoreboard", bus.Hresp, bus.Hrdata);
          end else begin
            e = exp_q.pop_front();
            if ({bus.Hresp, bus.Hrdata} !== {e.resp, e.rdata})
              $display("FAIL sb_done: got resp=%0b rdata=%h, expected resp=%0b rdata=%h",
                       bus.Hresp, bus.Hrdata, e.resp, e.rdata);
            else n_pass++;
          end
        end else begin
          n_total++;
          if (bus.Hresp !== 1'b0) $display("FAIL hresp_idle: got %0b, expected 0", bus.Hresp);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic obs_b2b();
    if (bus.done) b_done++;
    if (bus.Psel != 4'b0000 && !bus.Penable) b_addrs.push_back(bus.Paddr);
    else if (b_addrs.size() > 0 && b_done < 3 && bus.Psel == 4'b0000) b_gap++;
  endtask

  task automatic test_reset();
    Hreset = 1'b1;
    tick();
    tick();
    n_total++;
    if ({bus.Psel, bus.Penable, bus.Pwrite, bus.done, bus.Hresp} !== 8'd0)
      $display("FAIL reset_ctrl: got psel/en/wr/done/resp=%b, expected 0",
               {bus.Psel, bus.Penable, bus.Pwrite, bus.done, bus.Hresp});
    else n_pass++;
    n_total++;
    if ({bus.Paddr, bus.Pwdata, bus.Hrdata} !== 96'd0)
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, expected 0", bus.Paddr, bus.Pwdata, bus.Hrdata);
    else n_pass++;
    n_total++;
    if (bus.Hreadyout !== 1'b1) $display("FAIL reset_hreadyout: got %0b, expected 1", bus.Hreadyout);
    else n_pass++;
    Hreset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    bus.Pready      = 1'b1;
    bus.Pslverr     = 1'b0;
    bus.valid       = 1'b1;
    bus.Haddr_temp  = 32'h0000_2004;
    bus.Hwdata_temp = 32'hCAFE_F00D;
    bus.Hwrite_temp = 1'b1;
    expect_done(1'b0, 1'b0, 32'd0);
    tick();
    bus.valid = 1'b0;
    n_total++;
    if (bus.Psel !== 4'b0000) $display("FAIL wr_push_idle: psel got %b, expected 0000", bus.Psel);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.Psel, bus.Penable} !== 5'b0100_0) $display("FAIL wr_setup: psel/en got %b, expected 01000", {bus.Psel, bus.Penable});
    else n_pass++;
    n_total++;
    if ({bus.Paddr, bus.Pwdata, bus.Pwrite} !== {32'h0000_2004, 32'hCAFE_F00D, 1'b1})
      $display("FAIL wr_setup_bus: got addr=%h wdata=%h wr=%0b, expected 00002004 cafef00d 1", bus.Paddr, bus.Pwdata, bus.Pwrite);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.Psel, bus.Penable, bus.done} !== 6'b0100_1_0)
      $display("FAIL wr_access: psel/en/done got %b, expected 010010", {bus.Psel, bus.Penable, bus.done});
    else n_pass++;
    tick();
    n_total++;
    if ({bus.done, bus.Hresp, bus.Psel, bus.Penable} !== 7'b1_0_0000_0)
      $display("FAIL wr_done: done/resp/psel/en got %b, expected 1000000", {bus.done, bus.Hresp, bus.Psel, bus.Penable});
    else n_pass++;
    tick();
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL wr_done_pulse: done got %0b, expected 0", bus.done);
    else n_pass++;
  endtask

  task automatic test_read_wait();
    int n_en;
    bit got;
    bus.Pready      = 1'b0;
    bus.valid       = 1'b1;
    bus.Haddr_temp  = 32'h0000_3000;
    bus.Hwdata_temp = 32'd0;
    bus.Hwrite_temp = 1'b0;
    bus.Prdata      = 32'h1234_5678;
    expect_done(1'b0, 1'b1, 32'h1234_5678);
    tick();
    bus.valid = 1'b0;
    tick();
    n_total++;
    if ({bus.Psel, bus.Penable} !== 5'b1000_0) $display("FAIL rd_setup: psel/en got %b, expected 10000", {bus.Psel, bus.Penable});
    else n_pass++;
    n_en = 0;
    got  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.Penable) n_en++;
      if (n_en == 3) bus.Pready = 1'b1;
    end
    n_total++;
    if (!got) $display("FAIL rd_done_timeout: done got 0 within 20 cycles, expected 1");
    else n_pass++;
    n_total++;
    if (n_en !== 3) $display("FAIL rd_penable_cycles: got %0d, expected 3", n_en);
    else n_pass++;
    n_total++;
    if (bus.Hrdata !== 32'h1234_5678) $display("FAIL rd_hrdata: got %h, expected 12345678", bus.Hrdata);
    else n_pass++;
    bus.Pready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    b_done = 0;
    b_gap  = 0;
    b_addrs.delete();
    bus.Pready      = 1'b0;
    bus.Hwrite_temp = 1'b1;
    bus.valid       = 1'b1;
    bus.Haddr_temp  = 32'h0000_0010;
    bus.Hwdata_temp = 32'h1111_0000;
    expect_done(1'b0, 1'b0, 32'd0);
    tick();
    obs_b2b();
    n_total++;
    if (bus.Hreadyout !== 1'b1) $display("FAIL b2b_ready_1: got %0b, expected 1", bus.Hreadyout);
    else n_pass++;
    bus.Haddr_temp  = 32'h0000_1020;
    bus.Hwdata_temp = 32'h2222_0000;
    expect_done(1'b0, 1'b0, 32'd0);
    tick();
    obs_b2b();
    n_total++;
    if (bus.Hreadyout !== 1'b0) $display("FAIL b2b_full: got %0b, expected 0", bus.Hreadyout);
    else n_pass++;
    bus.Haddr_temp  = 32'h0000_2030;
    bus.Hwdata_temp = 32'h3333_0000;
    expect_done(1'b0, 1'b0, 32'd0);
    tick();
    obs_b2b();
    n_total++;
    if (bus.Hreadyout !== 1'b0) $display("FAIL b2b_held_off: got %0b, expected 0", bus.Hreadyout);
    else n_pass++;
    bus.Pready = 1'b1;
    tick();
    obs_b2b();
    n_total++;
    if (bus.Hreadyout !== 1'b1) $display("FAIL b2b_no_push_when_full: hreadyout got %0b, expected 1", bus.Hreadyout);
    else n_pass++;
    tick();
    obs_b2b();
    bus.valid = 1'b0;
    for (int i = 0; i < 20 && b_done < 3; i++) begin
      tick();
      obs_b2b();
    end
    n_total++;
    if (b_done !== 3) $display("FAIL b2b_done_count: got %0d, expected 3", b_done);
    else n_pass++;
    n_total++;
    if (b_gap !== 0) $display("FAIL b2b_idle_gap: got %0d idle cycles, expected 0", b_gap);
    else n_pass++;
    n_total++;
    if (b_addrs.size() !== 3) $display("FAIL b2b_setup_count: got %0d, expected 3", b_addrs.size());
    else if ({b_addrs[0], b_addrs[1], b_addrs[2]} !== {32'h0000_0010, 32'h0000_1020, 32'h0000_2030})
      $display("FAIL b2b_order: got %h %h %h, expected 00000010 00001020 00002030", b_addrs[0], b_addrs[1], b_addrs[2]);
    else n_pass++;
    bus.Pready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int          n_en;
    bit          got;
    logic [31:0] h_before;
    h_before        = m_hrdata;
    bus.Pready      = 1'b0;
    bus.valid       = 1'b1;
    bus.Haddr_temp  = 32'h0000_1000;
    bus.Hwrite_temp = 1'b0;
    bus.Prdata      = 32'hDEAD_BEEF;
    expect_done(1'b1, 1'b0, 32'd0);
    tick();
    bus.valid = 1'b0;
    n_en = 0;
    got  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.Penable) n_en++;
    end
    n_total++;
    if (!got) $display("FAIL to_done_timeout: done got 0 within 20 cycles, expected 1");
    else n_pass++;
    n_total++;
    if (n_en !== 4) $display("FAIL to_access_cycles: got %0d, expected 4", n_en);
    else n_pass++;
    n_total++;
    if ({bus.Hresp, bus.Hrdata} !== {1'b1, h_before})
      $display("FAIL to_resp_rdata: got resp=%0b rdata=%h, expected 1 %h", bus.Hresp, bus.Hrdata, h_before);
    else n_pass++;
    n_total++;
    if ({bus.Psel, bus.Penable, bus.Hreadyout} !== 6'b0000_0_1)
      $display("FAIL to_idle: psel/en/ready got %b, expected 000001", {bus.Psel, bus.Penable, bus.Hreadyout});
    else n_pass++;
    tick();
  endtask

  task automatic test_slave_error();
    int n_done;
    bus.Pready      = 1'b1;
    bus.Pslverr     = 1'b1;
    bus.valid       = 1'b1;
    bus.Haddr_temp  = 32'h0000_3004;
    bus.Hwdata_temp = 32'h5555_AAAA;
    bus.Hwrite_temp = 1'b1;
    expect_done(1'b1, 1'b0, 32'd0);
    tick();
    bus.Haddr_temp  = 32'h0000_1004;
    bus.Hwrite_temp = 1'b0;
    bus.Prdata      = 32'hA5A5_0001;
    expect_done(1'b0, 1'b1, 32'hA5A5_0001);
    tick();
    bus.valid = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20 && n_done < 2; i++) begin
      tick();
      if (bus.done) begin
        n_done++;
        n_total++;
        if (n_done == 1) begin
          if (bus.Hresp !== 1'b1) $display("FAIL err_resp: got %0b, expected 1", bus.Hresp);
          else n_pass++;
          bus.Pslverr = 1'b0;
        end else begin
          if ({bus.Hresp, bus.Hrdata} !== {1'b0, 32'hA5A5_0001})
            $display("FAIL err_next_ok: got resp=%0b rdata=%h, expected 0 a5a50001", bus.Hresp, bus.Hrdata);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (n_done !== 2) $display("FAIL err_done_count: got %0d, expected 2", n_done);
    else n_pass++;
    bus.Pready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    bit found;
    int n_done;
    bus.Pready      = 1'b0;
    bus.valid       = 1'b1;
    bus.Haddr_temp  = 32'h0000_2008;
    bus.Hwdata_temp = 32'h7777_8888;
    bus.Hwrite_temp = 1'b1;
    tick();
    bus.valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.Penable) begin
        found = 1'b1;
        break;
      end
    end
    n_total++;
    if (!found) $display("FAIL rst_reach_access: penable got 0 within 10 cycles, expected 1");
    else n_pass++;
    Hreset = 1'b1;
    #1;
    n_total++;
    if ({bus.Psel, bus.Penable, bus.done, bus.Hreadyout} !== 7'b0000_0_0_1)
      $display("FAIL rst_async: psel/en/done/ready got %b, expected 0000001", {bus.Psel, bus.Penable, bus.done, bus.Hreadyout});
    else n_pass++;
    exp_q.delete();
    m_hrdata = 32'd0;
    tick();
    tick();
    Hreset     = 1'b0;
    bus.Pready = 1'b1;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    n_total++;
    if (n_done !== 0) $display("FAIL rst_no_done: got %0d done pulses, expected 0", n_done);
    else n_pass++;
    bus.Pready = 1'b0;
  endtask

  initial begin
    n_pass          = 0;
    n_total         = 0;
    m_hrdata        = 32'd0;
    Hreset          = 1'b1;
    bus.valid       = 1'b0;
    bus.Haddr_temp  = 32'd0;
    bus.Hwdata_temp = 32'd0;
    bus.Hwrite_temp = 1'b0;
    bus.Pready      = 1'b0;
    bus.Prdata      = 32'd0;
    bus.Pslverr     = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_slave_error();
    test_reset_mid_access();
    tick();
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum number of ACCESS cycles with Pready low before the transfer is aborted; legal range 2..255.
REQ-002 SHALL have port Hclk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Hreset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port valid, input, 1 bit: request strobe from the AHB-side front end.
REQ-005 SHALL have port Haddr_temp, input, 32 bits: request address.
REQ-006 SHALL have port Hwdata_temp, input, 32 bits: request write data.
REQ-007 SHALL have port Hwrite_temp, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port Hreadyout, output, 1 bit: request buffer can accept a request.
REQ-009 SHALL have port Paddr, output, 32 bits: APB address.
REQ-010 SHALL have port Pwdata, output, 32 bits: APB write data.
REQ-011 SHALL have port Pwrite, output, 1 bit: APB direction.
REQ-012 SHALL have port Psel, output, 4 bits: one-hot APB slave select.
REQ-013 SHALL have port Penable, output, 1 bit: APB access phase.
REQ-014 SHALL have port Pready, input, 1 bit: APB slave ready.
REQ-015 SHALL have port Prdata, input, 32 bits: APB read data.
REQ-016 SHALL have port Pslverr, input, 1 bit: APB slave error.
REQ-017 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port Hrdata, output, 32 bits: captured read data.
REQ-019 SHALL have port Hresp, output, 1 bit: error flag, valid while done = 1.

Function
REQ-020 SHALL accept a request on a rising edge where valid = 1 and Hreadyout = 1, pushing {addr, wdata, write} into a 2-entry FIFO.
REQ-021 SHALL drive Hreadyout = 1 while the FIFO count is below 2, taken from registered count only; a pop on the same edge SHALL NOT permit a push while the FIFO is full.
REQ-022 SHALL implement the states IDLE, SETUP and ACCESS, with all APB outputs registered.
REQ-023 SHALL move IDLE -> SETUP on the edge after the FIFO becomes non-empty; Psel goes one-hot from the FIFO-head Paddr[13:12] (00 -> 0001 ... 11 -> 1000), with Paddr, Pwdata and Pwrite taken from the head, and Penable = 0.
REQ-024 SHALL always move SETUP -> ACCESS after one cycle, with Penable = 1 and Paddr, Pwdata, Pwrite and Psel held stable.
REQ-025 SHALL, in ACCESS with Pready = 1: pop the FIFO, pulse done for one cycle, set Hresp = Pslverr, load Hrdata = Prdata for a read (hold it for a write), drop Penable, then go to SETUP if another entry remains or was pushed on that edge, otherwise go to IDLE with Psel = 0.
REQ-026 SHALL count consecutive ACCESS cycles with Pready = 0 using an 8-bit wait counter, cleared on entry to ACCESS.
REQ-027 SHALL, when the wait count reaches TIMEOUT - 1 with Pready still 0, abort: pop the entry, pulse done with Hresp = 1, leave Hrdata unchanged, and go to IDLE or SETUP per REQ-025.
REQ-028 SHALL hold Hresp at 0 whenever done = 0.
REQ-029 SHALL give a minimum latency, from the push edge to done, of 3 edges: SETUP at push+1, ACCESS at push+2, done after push+3 when Pready = 1.
REQ-030 SHALL ignore Pready and Pslverr outside ACCESS.

Reset
REQ-031 SHALL, while Hreset = 1, immediately force state IDLE, FIFO count 0, Hreadyout = 1, Psel = 0, Penable = 0, Paddr = 0, Pwdata = 0, Pwrite = 0, done = 0, Hresp = 0, Hrdata = 0 and wait count 0.
REQ-032 SHALL discard an in-flight APB transfer on reset assertion, with no done pulse.

Verification
REQ-033 SHALL pass a single write: valid with addr 0x0000_2004, data 0xCAFE_F00D, write = 1, and Pready tied to 1 -> SETUP with Psel = 0100 and Penable = 0, then ACCESS with Penable = 1, then done = 1 and Hresp = 0 exactly 3 edges after the push.
REQ-034 SHALL pass a read with wait states: read addr 0x0000_3000, Pready low for 2 ACCESS cycles, Prdata = 0x1234_5678 -> Psel = 1000, Penable high for 3 cycles, done with Hrdata = 0x1234_5678.
REQ-035 SHALL pass back-to-back traffic: 3 writes pushed on consecutive cycles while Pready = 0 -> Hreadyout falls after 2 pushes and the third request is held off; with Pready = 1, transfers run SETUP/ACCESS with no IDLE gap and 3 done pulses arrive in push order.
REQ-036 SHALL pass a timeout with TIMEOUT = 4 and Pready held at 0 -> done with Hresp = 1 after the 4th ACCESS cycle, Hrdata unchanged, and state IDLE.
REQ-037 SHALL pass a slave error: Pslverr = 1 with Pready = 1 -> done with Hresp = 1, and the next transfer completes with Hresp = 0.
REQ-038 SHALL pass reset mid-ACCESS: Hreset asserted during ACCESS -> Psel, Penable and done are 0 at once, Hreadyout = 1, and no done pulse follows release.
